// File: rtl/uart_rx_ctrl.sv
// Receive-side sequencer for the UART.
// Synchronises rx, finds the start bit, strobes the external SIPO register once
// per data bit at mid-bit, checks the stop bit and reports the byte or a framing
// error with a one-cycle pulse.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  S_IDLE  | line idle, waiting for rx_s low
//  S_START | half-bit delay, re-check start bit (glitch filter)
//  S_DATA  | one strobe to SIPO per bit time at mid-bit, DATA_BITS times
//  S_STOP  | sample stop bit at mid-bit; good byte or framing error
//  S_BREAK | stop bit was low; wait for line to return high
module uart_rx_ctrl #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 sipo_en,
  output logic                 sipo_din,
  input  logic [DATA_BITS-1:0] sipo_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_nxt;
  logic             rx_m, rx_s;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             cnt_clr;
  logic             idx_inc;
  logic             load;
  logic             err;

  // Two-flop synchroniser; resets to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode, SIPO strobe and end-of-frame decisions.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    idx_inc   = 1'b0;
    load      = 1'b0;
    err       = 1'b0;
    sipo_en   = 1'b0;
    sipo_din  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_nxt = S_START;
      end
      S_START: begin
        if (cnt == CNT_HALF) state_nxt = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          sipo_en  = 1'b1;
          sipo_din = rx_s;
          idx_inc  = 1'b1;
          cnt_clr  = 1'b1;
          if (idx == IDX_LAST) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          if (rx_s) begin
            load      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            err       = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_clr = 1'b1;
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt != state) cnt_clr = 1'b1;
  end

  // Baud counter: free-runs inside a state, restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

  // Data-bit index; only meaningful in S_DATA, held at zero elsewhere.
  always_ff @(posedge clk) begin
    if (rst || state != S_DATA) idx <= '0;
    else if (idx_inc)           idx <= idx + 1'b1;
  end

  // Result registers; SIPO output is already in LSB-first order and is taken as-is.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= load;
      frame_err <= err;
      if (load) rx_data <= sipo_data;
    end
  end

  assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 10 clocks per bit with a SIPO_reg model.
module tb_uart_rx_ctrl;

  localparam int CPB = 10;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       sipo_en;
  logic       sipo_din;
  logic [7:0] sipo_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_en = -1000;
  int en_cnt = 0;
  int val_cnt = 0;
  int fe_cnt = 0;
  logic valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_ctrl #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000),
    .DATA_BITS(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .sipo_en  (sipo_en),
    .sipo_din (sipo_din),
    .sipo_data(sipo_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SIPO_reg model: shift right, serial_in enters the MSB.
  initial sipo_data = 8'h00;
  always @(posedge clk) if (sipo_en) sipo_data <= {sipo_din, sipo_data[7:1]};

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor away from the active edge: pulse counts, strobe spacing, scoreboard, invariants.
  always @(negedge clk) begin
    cyc++;
    if (sipo_en) begin
      en_cnt++;
      if (cyc - last_en < 25) chk("en_spacing", cyc - last_en, CPB);
      last_en = cyc;
      if (!rx_busy) chk("en_outside_frame", 1, 0);
    end
    if (rx_valid) begin
      val_cnt++;
      if (exp_q.size() > 0) chk("scoreboard_rx_data", rx_data, exp_q.pop_front());
      else chk("unexpected_valid", 1, 0);
      if (valid_prev) chk("valid_width", 2, 1);
    end
    if (frame_err) fe_cnt++;
    if (rx_valid && frame_err) chk("valid_err_excl", 1, 0);
    valid_prev = rx_valid;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit push);
    if (push) exp_q.push_back(b);
    rx = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(CPB);
    end
    rx = stop;
    wait_clk(CPB);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, v0, f0;
    logic [7:0] rb;
    rst = 1'b1;
    rx  = 1'b1;
    wait_clk(4);
    chk("reset_busy", rx_busy, 0);
    chk("reset_en", sipo_en, 0);
    chk("reset_din", sipo_din, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_valid", rx_valid, 0);
    chk("reset_ferr", frame_err, 0);
    rst = 1'b0;
    wait_clk(5);

    // 1: single good frame
    e0 = en_cnt; v0 = val_cnt; f0 = fe_cnt;
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_clk(5);
    chk("t1_en_pulses", en_cnt - e0, 8);
    chk("t1_valid_pulses", val_cnt - v0, 1);
    chk("t1_ferr", fe_cnt - f0, 0);
    chk("t1_rx_data", rx_data, 8'hA5);
    chk("t1_busy_idle", rx_busy, 0);

    // 2: back-to-back frames, no idle gap
    v0 = val_cnt;
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    wait_clk(5);
    chk("t2_valid_pulses", val_cnt - v0, 2);
    chk("t2_rx_data", rx_data, 8'hFF);

    // 3: 3-clock glitch is rejected
    e0 = en_cnt; v0 = val_cnt;
    rx = 1'b0;
    wait_clk(3);
    rx = 1'b1;
    chk("t3_busy_during", rx_busy, 1);
    wait_clk(5);
    chk("t3_busy_dropped", rx_busy, 0);
    wait_clk(20);
    chk("t3_no_en", en_cnt - e0, 0);
    chk("t3_no_valid", val_cnt - v0, 0);

    // 4: stop bit low, then line held low
    e0 = en_cnt; v0 = val_cnt; f0 = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    wait_clk(50);
    chk("t4_ferr_pulses", fe_cnt - f0, 1);
    chk("t4_no_valid", val_cnt - v0, 0);
    chk("t4_en_only_frame", en_cnt - e0, 8);
    chk("t4_rx_data_kept", rx_data, 8'hFF);
    chk("t4_busy_in_break", rx_busy, 1);
    rx = 1'b1;
    wait_clk(5);
    chk("t4_busy_released", rx_busy, 0);
    chk("t4_en_after_release", en_cnt - e0, 8);

    // 5: reset during bit 4 of 0x81, then a clean 0x81
    v0 = val_cnt; f0 = fe_cnt;
    rb = 8'h81;
    rx = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = rb[i];
      wait_clk(CPB);
    end
    rx = rb[4];
    wait_clk(5);
    rst = 1'b1;
    rx  = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    chk("t5_busy", rx_busy, 0);
    chk("t5_en", sipo_en, 0);
    chk("t5_din", sipo_din, 0);
    chk("t5_data", rx_data, 0);
    chk("t5_valid", rx_valid, 0);
    chk("t5_ferr", frame_err, 0);
    wait_clk(20);
    chk("t5_no_pulse", (val_cnt - v0) + (fe_cnt - f0), 0);
    send_frame(8'h81, 1'b1, 1'b1);
    wait_clk(5);
    chk("t5_rx_data", rx_data, 8'h81);

    // 6: random back-to-back frames through the scoreboard
    v0 = val_cnt; f0 = fe_cnt;
    for (int k = 0; k < 300; k++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    wait_clk(20);
    chk("t6_valid_count", val_cnt - v0, 300);
    chk("t6_no_ferr", fe_cnt - f0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
